// File: rtl/pattern_seq_matcher_if.sv
// Symbol-entry and status bundle between the keypad FSM, the pattern matcher and the unlock driver.
// The master drives symbols and commands; the slave (matcher) returns the registered status.
interface pattern_seq_matcher_if #(
  parameter int SYM_W     = 2,
  parameter int LEN       = 4,
  parameter int MAX_TRIES = 3
);
  localparam int PROG_W = $clog2(LEN + 1);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);

  logic                   sym_valid;
  logic [SYM_W-1:0]       sym;
  logic                   clear;
  logic                   pat_load;
  logic [LEN*SYM_W-1:0]   pat_in;
  logic                   grant;
  logic                   deny;
  logic                   locked;
  logic [PROG_W-1:0]      progress;
  logic [FAIL_W-1:0]      fails;

  modport master (
    output sym_valid, sym, clear, pat_load, pat_in,
    input  grant, deny, locked, progress, fails
  );

  modport slave (
    input  sym_valid, sym, clear, pat_load, pat_in,
    output grant, deny, locked, progress, fails
  );
endinterface

// File: rtl/pattern_seq_matcher.sv
// Serial access-pattern checker: compares LEN entered symbols against a loadable reference,
// pulses grant/deny after the last symbol and locks out for LOCK_CYCLES after MAX_TRIES denies.
module pattern_seq_matcher #(
  parameter int                       SYM_W       = 2,
  parameter int                       LEN         = 4,
  parameter int                       MAX_TRIES   = 3,
  parameter int                       LOCK_CYCLES = 16,
  parameter logic [LEN*SYM_W-1:0]     PATTERN     = 8'hB4
) (
  input  logic                  clk,
  input  logic                  rst,
  pattern_seq_matcher_if.slave  bus
);
  localparam int PAT_W  = LEN * SYM_W;
  localparam int PROG_W = $clog2(LEN + 1);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int CNT_W  = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [PROG_W-1:0]   progress_q, progress_d;
  logic                mis_q, mis_d;
  logic [FAIL_W-1:0]   fails_q, fails_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                grant_q, grant_d;
  logic                deny_q, deny_d;
  logic                locked_q, locked_d;
  logic                mis_nxt;

  // Symbol k is taken MSB group first; constant-index loop keeps the select width-clean.
  function automatic logic [SYM_W-1:0] sym_at(input logic [PAT_W-1:0] p,
                                              input logic [PROG_W-1:0] k);
    logic [SYM_W-1:0] r;
    r = '0;
    for (int i = 0; i < LEN; i++) begin
      if (PROG_W'(i) == k) r = p[(LEN-1-i)*SYM_W +: SYM_W];
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    progress_d = progress_q;
    mis_d      = mis_q;
    fails_d    = fails_q;
    cnt_d      = cnt_q;
    grant_d    = 1'b0;
    deny_d     = 1'b0;
    locked_d   = locked_q;
    mis_nxt    = 1'b0;

    case (state_q)
      IDLE, COLLECT: begin
        if (bus.clear) begin
          progress_d = '0;
          mis_d      = 1'b0;
          state_d    = IDLE;
        end else if (bus.sym_valid) begin
          mis_nxt = mis_q | (bus.sym != sym_at(pat_q, progress_q));
          if (progress_q == PROG_W'(LEN - 1)) begin
            progress_d = '0;
            mis_d      = 1'b0;
            if (!mis_nxt) begin
              grant_d = 1'b1;
              fails_d = '0;
              state_d = IDLE;
            end else begin
              deny_d = 1'b1;
              if (fails_q == FAIL_W'(MAX_TRIES - 1)) begin
                fails_d  = FAIL_W'(MAX_TRIES);
                locked_d = 1'b1;
                cnt_d    = CNT_W'(LOCK_CYCLES);
                state_d  = LOCKOUT;
              end else begin
                fails_d = fails_q + 1'b1;
                state_d = IDLE;
              end
            end
          end else begin
            progress_d = progress_q + 1'b1;
            mis_d      = mis_nxt;
            state_d    = COLLECT;
          end
        end
        // A new reference only takes effect between attempts; the symbol above used the old one.
        if (state_q == IDLE && progress_q == '0 && bus.pat_load) pat_d = bus.pat_in;
      end
      LOCKOUT: begin
        if (cnt_q == CNT_W'(1)) begin
          locked_d = 1'b0;
          fails_d  = '0;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pat_q      <= PATTERN;
      progress_q <= '0;
      mis_q      <= 1'b0;
      fails_q    <= '0;
      cnt_q      <= '0;
      grant_q    <= 1'b0;
      deny_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      progress_q <= progress_d;
      mis_q      <= mis_d;
      fails_q    <= fails_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      deny_q     <= deny_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.deny     = deny_q;
  assign bus.locked   = locked_q;
  assign bus.progress = progress_q;
  assign bus.fails    = fails_q;
endmodule
